// File: rtl/dequant_32x8b_if.sv
// Beat handshake and data bus for the 32-lane int8 -> int16 dequantizer.
interface dequant_32x8b_if #(
  parameter int NUM_LANES = 32
);
  logic                           i_in_vld;
  logic                           o_in_rdy;
  logic [NUM_LANES-1:0][7:0]      i_dat;
  logic [NUM_LANES-1:0]           i_bypass;
  logic                           o_out_vld;
  logic                           i_out_rdy;
  logic [NUM_LANES-1:0][15:0]     o_dat;
  logic                           o_sat_flag;

  modport master (
    output i_in_vld, i_dat, i_bypass, i_out_rdy,
    input  o_in_rdy, o_out_vld, o_dat, o_sat_flag
  );

  modport slave (
    input  i_in_vld, i_dat, i_bypass, i_out_rdy,
    output o_in_rdy, o_out_vld, o_dat, o_sat_flag
  );
endinterface

// File: rtl/dequant_32x8b.sv
// Two-stage int8 -> int16 dequantizer: per-lane arithmetic left shift with
// signed saturation, per-lane bypass, and a sticky count of saturated beats.
module dequant_32x8b_lane (
  input  logic [7:0]  x,
  input  logic [4:0]  s,
  input  logic        byp,
  output logic [15:0] y,
  output logic        sat
);
  logic signed [39:0] t;

  // 40 bits holds an int8 shifted by up to 31 with no loss
  always_comb begin
    t   = 40'(signed'(x)) <<< s;
    y   = t[15:0];
    sat = 1'b0;
    if (byp) begin
      y = {{8{x[7]}}, x};
    end else if (t > 40'sd32767) begin
      y   = 16'h7FFF;
      sat = 1'b1;
    end else if (t < -40'sd32768) begin
      y   = 16'h8000;
      sat = 1'b1;
    end
  end
endmodule

module dequant_32x8b (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_q_encode,
  input  logic [3:0]  w_q_encode,
  input  logic [3:0]  o_q_encode,
  input  logic        i_shift_en,
  input  logic        i_sat_clr,
  output logic [15:0] o_sat_cnt,
  dequant_32x8b_if.slave bus
);
  localparam int NUM_LANES = 32;

  logic [4:0]                  shift_reg;
  logic                        shift_en_q;
  logic [4:0]                  s;
  logic                        s1_vld, s2_vld, s1_adv;
  logic [NUM_LANES-1:0][7:0]   s1_dat;
  logic [NUM_LANES-1:0]        s1_byp;
  logic [NUM_LANES-1:0][15:0]  lane_y;
  logic [NUM_LANES-1:0]        lane_sat;

  assign s             = shift_en_q ? shift_reg : 5'd0;
  assign s1_adv        = !s2_vld || bus.i_out_rdy;
  assign bus.o_in_rdy  = !s1_vld || s1_adv;
  assign bus.o_out_vld = s2_vld;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dequant_32x8b_lane u_lane (
      .x   (s1_dat[i]),
      .s   (s),
      .byp (s1_byp[i]),
      .y   (lane_y[i]),
      .sat (lane_sat[i])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_reg      <= '0;
      shift_en_q     <= 1'b0;
      s1_vld         <= 1'b0;
      s2_vld         <= 1'b0;
      s1_dat         <= '0;
      s1_byp         <= '0;
      bus.o_dat      <= '0;
      bus.o_sat_flag <= 1'b0;
      o_sat_cnt      <= '0;
    end else begin
      // shift only reloads on an empty pipeline so in-flight beats keep theirs
      if (!s1_vld && !s2_vld) begin
        shift_reg  <= {1'b0, i_q_encode} + {1'b0, w_q_encode} - {1'b0, o_q_encode};
        shift_en_q <= i_shift_en;
      end

      if (bus.i_in_vld && bus.o_in_rdy) begin
        s1_vld <= 1'b1;
        s1_dat <= bus.i_dat;
        s1_byp <= bus.i_bypass;
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end

      if (s1_vld && s1_adv) begin
        s2_vld         <= 1'b1;
        bus.o_dat      <= lane_y;
        bus.o_sat_flag <= |lane_sat;
      end else if (bus.i_out_rdy) begin
        s2_vld <= 1'b0;
      end

      if (i_sat_clr)
        o_sat_cnt <= '0;
      else if (s2_vld && bus.i_out_rdy && bus.o_sat_flag && o_sat_cnt != 16'hFFFF)
        o_sat_cnt <= o_sat_cnt + 16'd1;
    end
  end
endmodule
